// File: rtl/apb4_sram_pkg.sv
// Shared types and helpers for the APB4 SRAM slave: FSM state encoding,
// derived-width helpers and the address error decode.
package apb4_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  // Reference configuration (32-bit data, 16 words). Modules derive their
  // own values from their parameters with the helpers below.
  localparam int STRB_W = 32 / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(16);

  // Width of the address vector handed to addr_err; callers zero-extend.
  localparam int ERR_ADDR_W = 64;

  function automatic int calc_strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int calc_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Error when any byte-offset bit (below lsb) or any bit above the
  // word-index field is set: misaligned or out-of-range access.
  function automatic logic addr_err(input logic [ERR_ADDR_W-1:0] addr,
                                    input int lsb,
                                    input int idx_w);
    logic err;
    err = 1'b0;
    for (int i = 0; i < ERR_ADDR_W; i++) begin
      if (((i < lsb) || (i >= lsb + idx_w)) && addr[i]) begin
        err = 1'b1;
      end
    end
    return err;
  endfunction

endpackage

// File: rtl/apb4_sram_slave_if.sv
// APB4 bus bundle between the bridge (master) and the SRAM slave.
interface apb4_sram_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  iPsel;
  logic                  iPenable;
  logic                  iPwrite;
  logic [ADDR_W-1:0]     iPaddr;
  logic [DATA_W/8-1:0]   iPstrb;
  logic [DATA_W-1:0]     iPwdata;
  logic [DATA_W-1:0]     oPrdata;
  logic                  oPready;
  logic                  oPslverr;

  modport slave (
    input  iPsel, iPenable, iPwrite, iPaddr, iPstrb, iPwdata,
    output oPrdata, oPready, oPslverr
  );

  modport master (
    output iPsel, iPenable, iPwrite, iPaddr, iPstrb, iPwdata,
    input  oPrdata, oPready, oPslverr
  );
endinterface

// File: rtl/sp_sram_bwe.sv
// Single-port storage with per-byte write enable, registered read port and
// synchronous clear. Each byte lane is its own array so byte writes never
// need a read-modify-write.
module sp_sram_bwe #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int ADDR_N = $clog2(DEPTH),
  localparam int BYTE_N = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic [ADDR_N-1:0] addr_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [BYTE_N-1:0] be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  for (genvar gi = 0; gi < BYTE_N; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    logic [7:0] rd_q;

    // Byte lane: clear on reset, masked write, registered read.
    always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
        for (int w = 0; w < DEPTH; w++) begin
          lane_q[w] <= 8'h00;
        end
        rd_q <= 8'h00;
      end else begin
        if (we_i && be_i[gi]) begin
          lane_q[addr_i] <= wdata_i[gi*8 +: 8];
        end
        if (re_i) begin
          rd_q <= lane_q[addr_i];
        end
      end
    end

    assign rdata_o[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/apb4_sram_slave.sv
// APB4 slave fronting a byte-writable scratch memory. Transfers are captured
// in the setup phase, optionally stretched by WAIT_CYC wait states, and
// answered with PSLVERR for misaligned or out-of-range addresses. Every
// output is decoded from the state register and registered data, so no
// input reaches an output combinationally.
module apb4_sram_slave
  import apb4_sram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 0
) (
  input  logic               iClk,
  input  logic               iRsn,
  apb4_sram_slave_if.slave   apb
);

  localparam int STRB_N = calc_strb_w(DATA_W);
  localparam int LSB_N  = calc_lsb(DATA_W);
  localparam int IDX_N  = $clog2(DEPTH);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_N-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic [STRB_N-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                setup;
  logic [IDX_N-1:0]    paddr_idx;
  logic                paddr_err;
  logic                ram_re;
  logic                ram_we;
  logic [IDX_N-1:0]    ram_addr;
  logic [DATA_W-1:0]   ram_rdata;

  assign setup     = apb.iPsel & ~apb.iPenable;
  assign paddr_idx = apb.iPaddr[LSB_N+IDX_N-1:LSB_N];
  assign paddr_err = addr_err(ERR_ADDR_W'(apb.iPaddr), LSB_N, IDX_N);

  // The read that enters READY straight from IDLE must use the live address
  // because the capture happens on that same edge; later reads and the
  // write in READY use the captured index.
  assign ram_addr = (state_q == IDLE) ? paddr_idx : idx_q;

  // State, wait counter and setup-phase capture registers.
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic, capture on setup, storage read/write strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ram_re  = 1'b0;
    ram_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d   = paddr_idx;
          write_d = apb.iPwrite;
          strb_d  = apb.iPstrb;
          wdata_d = apb.iPwdata;
          err_d   = paddr_err;
          if (WAIT_CYC == 0) begin
            state_d = READY;
            ram_re  = ~apb.iPwrite;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYC);
          end
        end
      end

      WAIT: begin
        if (!apb.iPsel) begin
          // Master abandoned the transfer.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = READY;
          cnt_d   = 4'd0;
          ram_re  = ~write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      READY: begin
        state_d = IDLE;
        // Commit only if the master is still in a valid access phase, so a
        // dropped PSEL here leaves storage untouched.
        ram_we  = apb.iPsel & apb.iPenable & write_q & ~err_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sp_sram_bwe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (iClk),
    .rsn_i   (iRsn),
    .addr_i  (ram_addr),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .be_i    (strb_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign apb.oPready  = (state_q == READY);
  assign apb.oPslverr = (state_q == READY) & err_q;
  assign apb.oPrdata  = ((state_q == READY) && !err_q && !write_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_apb4_sram_slave.sv
// Directed bench for apb4_sram_slave: three instances (0, 2 and 3 wait
// states) share one stimulus set; sel routes PSEL to one of them.
module tb_apb4_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rsn;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  int          sel;

  logic [31:0] dut_rdata;
  logic        dut_ready, dut_slverr;

  int tests_run    = 0;
  int tests_failed = 0;

  apb4_sram_slave_if #(.DATA_W(32), .ADDR_W(16)) bus0 ();
  apb4_sram_slave_if #(.DATA_W(32), .ADDR_W(16)) bus2 ();
  apb4_sram_slave_if #(.DATA_W(32), .ADDR_W(16)) bus3 ();

  assign bus0.iPsel = psel & (sel == 0);
  assign bus2.iPsel = psel & (sel == 2);
  assign bus3.iPsel = psel & (sel == 3);
  assign bus0.iPenable = penable;  assign bus2.iPenable = penable;  assign bus3.iPenable = penable;
  assign bus0.iPwrite  = pwrite;   assign bus2.iPwrite  = pwrite;   assign bus3.iPwrite  = pwrite;
  assign bus0.iPaddr   = paddr;    assign bus2.iPaddr   = paddr;    assign bus3.iPaddr   = paddr;
  assign bus0.iPstrb   = pstrb;    assign bus2.iPstrb   = pstrb;    assign bus3.iPstrb   = pstrb;
  assign bus0.iPwdata  = pwdata;   assign bus2.iPwdata  = pwdata;   assign bus3.iPwdata  = pwdata;

  always_comb begin
    dut_rdata  = bus0.oPrdata;
    dut_ready  = bus0.oPready;
    dut_slverr = bus0.oPslverr;
    if (sel == 2) begin
      dut_rdata = bus2.oPrdata; dut_ready = bus2.oPready; dut_slverr = bus2.oPslverr;
    end else if (sel == 3) begin
      dut_rdata = bus3.oPrdata; dut_ready = bus3.oPready; dut_slverr = bus3.oPslverr;
    end
  end

  apb4_sram_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(16), .WAIT_CYC(0)) u_dut0 (
    .iClk(clk), .iRsn(rsn), .apb(bus0));
  apb4_sram_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(16), .WAIT_CYC(2)) u_dut2 (
    .iClk(clk), .iRsn(rsn), .apb(bus2));
  apb4_sram_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(16), .WAIT_CYC(3)) u_dut3 (
    .iClk(clk), .iRsn(rsn), .apb(bus3));

  // One APB transfer; starts and ends just after a rising edge. lat counts
  // access-phase cycles up to and including the PREADY cycle (-1 = timeout).
  task automatic apb_xfer(input int s, input logic wr, input logic [15:0] a,
                          input logic [3:0] st, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pstrb = st; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; rd = '0; err = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dut_ready && lat < 40);
    if (dut_ready) begin
      rd = dut_rdata; err = dut_slverr;
    end else begin
      lat = -1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    $display("[TB] dut%0d %s addr=0x%04h strb=0x%h wdata=0x%08h -> rdata=0x%08h slverr=%0b lat=%0d",
             s, wr ? "WR" : "RD", a, st, wd, rd, err, lat);
  endtask

  task automatic test_reset();
    int ids[3] = '{0, 2, 3};
    rsn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pstrb = '0; pwdata = '0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    foreach (ids[k]) begin
      sel = ids[k]; #1;
      tests_run++; if (dut_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready dut%0d: got %b want 0", sel, dut_ready); end
      tests_run++; if (dut_slverr !== 1'b0) begin tests_failed++; $display("FAIL reset_slverr dut%0d: got %b want 0", sel, dut_slverr); end
      tests_run++; if (dut_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata dut%0d: got %h want 0", sel, dut_rdata); end
    end
    @(posedge clk); #1;
    rsn = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1'b1, 16'h0004, 4'hF, 32'hDEADBEEF, rd, err, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL basic_wr_lat: got %0d want 1", lat); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_wr_err: got %b want 0", err); end
    apb_xfer(0, 1'b0, 16'h0004, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL basic_rd_lat: got %0d want 1", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_rd_err: got %b want 0", err); end
    @(negedge clk);
    tests_run++; if (dut_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_ready: got %b want 0", dut_ready); end
    tests_run++; if (dut_rdata !== 32'h0) begin tests_failed++; $display("FAIL basic_idle_rdata: got %h want 0", dut_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1'b1, 16'h0008, 4'hF, 32'h11223344, rd, err, lat);
    apb_xfer(0, 1'b1, 16'h0008, 4'h5, 32'hAABBCCDD, rd, err, lat);
    apb_xfer(0, 1'b0, 16'h0008, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL strobe_partial: got %h want 11bb33dd", rd); end
    apb_xfer(0, 1'b1, 16'h0008, 4'h0, 32'hFFFFFFFF, rd, err, lat);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL strobe_zero_err: got %b want 0", err); end
    apb_xfer(0, 1'b0, 16'h0008, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL strobe_zero_noop: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_wait3();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(3, 1'b0, 16'h0000, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL wait3_rd_lat: got %0d want 4", lat); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL wait3_rd_data: got %h want 0", rd); end
    apb_xfer(3, 1'b1, 16'h0004, 4'hF, 32'h87654321, rd, err, lat);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL wait3_wr_lat: got %0d want 4", lat); end
    apb_xfer(3, 1'b0, 16'h0004, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h87654321) begin tests_failed++; $display("FAIL wait3_rd_back: got %h want 87654321", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1'b1, 16'h0000, 4'hF, 32'h01020304, rd, err, lat);
    apb_xfer(0, 1'b1, 16'h0040, 4'hF, 32'hFFFFFFFF, rd, err, lat);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_range_slverr: got %b want 1", err); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL err_range_lat: got %0d want 1", lat); end
    apb_xfer(0, 1'b0, 16'h0000, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h01020304) begin tests_failed++; $display("FAIL err_range_nowrite: got %h want 01020304", rd); end
    apb_xfer(0, 1'b1, 16'h0002, 4'hF, 32'hEEEEEEEE, rd, err, lat);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_align_slverr: got %b want 1", err); end
    apb_xfer(0, 1'b0, 16'h0000, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h01020304) begin tests_failed++; $display("FAIL err_align_nowrite: got %h want 01020304", rd); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL err_good_slverr: got %b want 0", err); end
    apb_xfer(0, 1'b0, 16'h8001, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_rd_slverr: got %b want 1", err); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL err_rd_data: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1'b1, 16'h001C, 4'hF, 32'h600DF00D, rd, err, lat);
    apb_xfer(0, 1'b0, 16'h001C, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h600DF00D) begin tests_failed++; $display("FAIL b2b_raw_data: got %h want 600df00d", rd); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL b2b_raw_lat: got %0d want 1", lat); end
  endtask

  task automatic test_capture();
    logic [31:0] rd; logic err; int lat;
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 16'h0014; pstrb = 4'hF; pwdata = 32'h0BADCAFE;
    @(posedge clk); #1;
    penable = 1'b1; paddr = 16'h0018; pstrb = 4'h0; pwdata = 32'h0; pwrite = 1'b0;
    @(negedge clk);
    tests_run++; if (dut_ready !== 1'b1) begin tests_failed++; $display("FAIL capture_ready: got %b want 1", dut_ready); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    $display("[TB] dut0 WR addr=0x0014 wdata=0x0badcafe with access-phase changes");
    apb_xfer(0, 1'b0, 16'h0014, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h0BADCAFE) begin tests_failed++; $display("FAIL capture_data: got %h want 0badcafe", rd); end
    apb_xfer(0, 1'b0, 16'h0018, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL capture_other: got %h want 0", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int lat;
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 16'h000C; pstrb = 4'hF; pwdata = 32'h12345678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    tests_run++; if (dut_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_acc1_ready: got %b want 0", dut_ready); end
    @(posedge clk); #1;
    psel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if (dut_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_ready_c%0d: got %b want 0", i, dut_ready); end
    end
    penable = 1'b0;
    @(posedge clk); #1;
    $display("[TB] dut2 WR addr=0x000c wdata=0x12345678 aborted");
    apb_xfer(2, 1'b0, 16'h000C, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL abort_nowrite: got %h want 0", rd); end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL abort_next_lat: got %0d want 3", lat); end
    apb_xfer(2, 1'b1, 16'h0024, 4'hF, 32'hA5A5A5A5, rd, err, lat);
    apb_xfer(2, 1'b0, 16'h0024, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL abort_recover: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat;
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 16'h0010; pstrb = 4'hF; pwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    penable = 1'b1;
    rsn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (dut_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready: got %b want 0", dut_ready); end
    tests_run++; if (dut_slverr !== 1'b0) begin tests_failed++; $display("FAIL rstmid_slverr: got %b want 0", dut_slverr); end
    tests_run++; if (dut_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstmid_rdata: got %h want 0", dut_rdata); end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rsn = 1'b1;
    $display("[TB] dut2 WR addr=0x0010 wdata=0xcafef00d interrupted by reset");
    apb_xfer(2, 1'b0, 16'h0010, 4'h0, 32'h0, rd, err, lat);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rstmid_nowrite: got %h want 0", rd); end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL rstmid_next_lat: got %0d want 3", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_wait3();
    test_errors();
    test_back_to_back();
    test_capture();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
